ram_arb: RTL

RAM_ARB -- requirements
Module: ram_arb

---
 rtl/ram_ctrl_pkg.sv | 17 +
 rtl/rr_arb2.sv | 88 ++++++++
 rtl/ram_arb.sv | 98 +++++++++
 3 files changed

// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared constants and FSM encoding for the RAM arbiter
// Purpose: state encoding of the ownership FSM, default burst limit and the
// width of the burst counter. No ports.
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  localparam int DEFAULT_MAX_BURST = 4;

  // MAX_BURST is limited to 1..15, so four bits always hold the count
  localparam int CNT_WIDTH = 4;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with a burst limit
// Purpose: picks at most one of two requesters per cycle. The current owner
// keeps the grant until it stops requesting, or until it has held the grant
// for MAX_BURST cycles while the other port waits.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   req0_i, req1_i    access requests
//   gnt0_o, gnt1_o    grants, combinational from state and requests
module rr_arb2
  import ram_ctrl_pkg::*;
#(
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_BURST);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  arb_state_t             state;
  logic                   rr;
  logic [CNT_WIDTH-1:0]   cnt;
  logic                   pick0;
  logic                   pick1;

  always_comb begin
    pick0 = 1'b0;
    pick1 = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req0_i && req1_i) begin
          pick0 = ~rr;
          pick1 = rr;
        end else begin
          pick0 = req0_i;
          pick1 = req1_i;
        end
      end
      // the owner yields only when its burst is used up and the other waits
      ST_OWN0: begin
        if (req0_i && !(req1_i && cnt == CNT_MAX)) pick0 = 1'b1;
        else                                       pick1 = req1_i;
      end
      ST_OWN1: begin
        if (req1_i && !(req0_i && cnt == CNT_MAX)) pick1 = 1'b1;
        else                                       pick0 = req0_i;
      end
      default: begin
        pick0 = 1'b0;
        pick1 = 1'b0;
      end
    endcase
  end

  // grants are forced low for the whole time reset is held
  assign gnt0_o = pick0 & rst_ni;
  assign gnt1_o = pick1 & rst_ni;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_IDLE;
      rr    <= 1'b0;
      cnt   <= '0;
    end else begin
      if (pick0) begin
        if (state == ST_OWN0) cnt <= (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
        else                  cnt <= CNT_ONE;
        // ownership moving away from port 1 records port 1 in rr
        if (state == ST_OWN1) rr <= 1'b1;
        state <= ST_OWN0;
      end else if (pick1) begin
        if (state == ST_OWN1) cnt <= (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
        else                  cnt <= CNT_ONE;
        if (state == ST_OWN0) rr <= 1'b0;
        state <= ST_OWN1;
      end else begin
        state <= ST_IDLE;
        cnt   <= '0;
      end
    end
  end

endmodule

// File: rtl/ram_arb.sv
// rtl/ram_arb.sv - two-port arbiter in front of a single-port registered RAM
// Purpose: muxes the granted port onto the RAM strobes/address/data and
// returns read data one cycle later to the port that issued the read.
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   req*_i, we*_i, addr*_i, wdata*_i   per-port access request
//   gnt*_o                             per-port grant (combinational)
//   rvalid*_o, rdata*_o                per-port read return, rdata 0 if not valid
//   ram_we_o, ram_rd_o, ram_addr_o,
//   ram_wdata_o, ram_rdata_i           single-port RAM interface
module ram_arb
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_BURST  = DEFAULT_MAX_BURST
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req0_i,
  input  logic                  we0_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [DATA_WIDTH-1:0] wdata0_i,
  input  logic                  req1_i,
  input  logic                  we1_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  output logic                  gnt0_o,
  output logic                  gnt1_o,
  output logic                  rvalid0_o,
  output logic                  rvalid1_o,
  output logic [DATA_WIDTH-1:0] rdata0_o,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  output logic                  ram_we_o,
  output logic                  ram_rd_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  logic gnt0;
  logic gnt1;
  logic pend_valid;
  logic pend_port;

  rr_arb2 #(
    .MAX_BURST (MAX_BURST)
  ) u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req0_i (req0_i),
    .req1_i (req1_i),
    .gnt0_o (gnt0),
    .gnt1_o (gnt1)
  );

  assign gnt0_o = gnt0;
  assign gnt1_o = gnt1;

  always_comb begin
    ram_we_o    = 1'b0;
    ram_rd_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (gnt0) begin
      ram_we_o    = we0_i;
      ram_rd_o    = ~we0_i;
      ram_addr_o  = addr0_i;
      ram_wdata_o = wdata0_i;
    end else if (gnt1) begin
      ram_we_o    = we1_i;
      ram_rd_o    = ~we1_i;
      ram_addr_o  = addr1_i;
      ram_wdata_o = wdata1_i;
    end
  end

  // One-entry pending register: the RAM answers exactly one cycle after the
  // read strobe, so a single slot is reloaded every cycle and a following
  // write cannot overwrite a read that is still in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_valid <= 1'b0;
      pend_port  <= 1'b0;
    end else begin
      pend_valid <= ram_rd_o;
      pend_port  <= gnt1;
    end
  end

  assign rvalid0_o = pend_valid & ~pend_port;
  assign rvalid1_o = pend_valid &  pend_port;

  // the RAM floats its output when idle; gating keeps Z off the ports
  assign rdata0_o = rvalid0_o ? ram_rdata_i : '0;
  assign rdata1_o = rvalid1_o ? ram_rdata_i : '0;

endmodule
